// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: turns one (origin, size, colour) command into a raster-ordered
// stream of single-pixel writes for the framebuffer adapter, clipped to the visible area.
module vga_rect_fill #(
  parameter int H_RES   = 160,
  parameter int V_RES   = 120,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 9
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [X_W-1:0]     w,
  input  logic [Y_W-1:0]     h,
  input  logic [COLOR_W-1:0] colour_in,
  output logic               ready,
  output logic               done,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] colour,
  output logic               plot
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic [X_W:0] H_END = H_RES[X_W:0];
  localparam logic [Y_W:0] V_END = V_RES[Y_W:0];

  state_e             state_q, state_d;
  logic [X_W-1:0]     x0_q, x0_d;
  logic [X_W-1:0]     cx_q, cx_d;
  logic [Y_W-1:0]     cy_q, cy_d;
  logic [X_W:0]       xe_q, xe_d;
  logic [Y_W:0]       ye_q, ye_d;
  logic [COLOR_W-1:0] col_q, col_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [Y_W-1:0]     y_q, y_d;
  logic [COLOR_W-1:0] colour_q, colour_d;
  logic               plot_q, plot_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;

  logic [X_W:0] xsum_s, xe_s, cx_inc_s;
  logic [Y_W:0] ysum_s, ye_s, cy_inc_s;
  logic         empty_s, row_end_s, last_s;

  // Clipped end bounds are one bit wider than the coordinates so x0+w can never wrap.
  always_comb begin
    xsum_s    = {1'b0, x0} + {1'b0, w};
    ysum_s    = {1'b0, y0} + {1'b0, h};
    xe_s      = (xsum_s > H_END) ? H_END : xsum_s;
    ye_s      = (ysum_s > V_END) ? V_END : ysum_s;
    empty_s   = (w == {X_W{1'b0}}) || (h == {Y_W{1'b0}}) ||
                ({1'b0, x0} >= H_END) || ({1'b0, y0} >= V_END);
    cx_inc_s  = {1'b0, cx_q} + {{X_W{1'b0}}, 1'b1};
    cy_inc_s  = {1'b0, cy_q} + {{Y_W{1'b0}}, 1'b1};
    row_end_s = (cx_inc_s == xe_q);
    last_s    = row_end_s && (cy_inc_s == ye_q);
  end

  // Next-state and next-output logic; the output registers always hold the pixel being shown.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    col_d    = col_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    ready_d  = ready_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          x0_d    = x0;
          col_d   = colour_in;
          xe_d    = xe_s;
          ye_d    = ye_s;
          ready_d = 1'b0;
          if (empty_s) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d  = DRAW;
            cx_d     = x0;
            cy_d     = y0;
            x_d      = x0;
            y_d      = y0;
            colour_d = colour_in;
            plot_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (last_s) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (row_end_s) begin
          cx_d     = x0_q;
          cy_d     = cy_inc_s[Y_W-1:0];
          x_d      = x0_q;
          y_d      = cy_inc_s[Y_W-1:0];
          colour_d = col_q;
          plot_d   = 1'b1;
        end else begin
          cx_d     = cx_inc_s[X_W-1:0];
          x_d      = cx_inc_s[X_W-1:0];
          y_d      = cy_q;
          colour_d = col_q;
          plot_d   = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      x0_q     <= {X_W{1'b0}};
      cx_q     <= {X_W{1'b0}};
      cy_q     <= {Y_W{1'b0}};
      xe_q     <= {(X_W+1){1'b0}};
      ye_q     <= {(Y_W+1){1'b0}};
      col_q    <= {COLOR_W{1'b0}};
      x_q      <= {X_W{1'b0}};
      y_q      <= {Y_W{1'b0}};
      colour_q <= {COLOR_W{1'b0}};
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      col_q    <= col_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;

endmodule
